// File: rtl/dual_port_ram_pkg.sv
// Shared constants and FSM encoding for the dual-port RAM bank.
package dual_port_ram_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultDepth = 4096;

  typedef logic [0:0] state_t;
  localparam state_t StClear = 1'b0;
  localparam state_t StRun   = 1'b1;

endpackage

// File: rtl/dual_port_ram_if.sv
// Port A (CPU) and port B (debug/UART) request/response bundle for dual_port_ram.
interface dual_port_ram_if
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = $clog2(DefaultDepth)
) ();

  logic                  a_req;
  logic [DATA_W/8-1:0]   a_we;
  logic [ADDR_W-1:0]     a_addr;
  logic [DATA_W-1:0]     a_wdata;
  logic                  a_ready;
  logic [DATA_W-1:0]     a_rdata;
  logic                  a_rvalid;

  logic                  b_req;
  logic                  b_we;
  logic [31:0]           b_addr;
  logic [DATA_W-1:0]     b_wdata;
  logic                  b_ready;
  logic [DATA_W-1:0]     b_rdata;
  logic                  b_rvalid;
  logic                  b_hit;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_ready, a_rdata, a_rvalid, b_ready, b_rdata, b_rvalid, b_hit
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_ready, a_rdata, a_rvalid, b_ready, b_rdata, b_rvalid, b_hit
  );

endinterface

// File: rtl/dual_port_ram_array_2p.sv
// Two-port synchronous storage, byte writes on A, full-word writes on B, no reset.
module ram_array_2p #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                clk_i,
  input  logic                a_en_i,
  input  logic [DATA_W/8-1:0] a_we_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_wdata_i,
  output logic [DATA_W-1:0]   a_rdata_o,
  input  logic                b_en_i,
  input  logic                b_we_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_wdata_i,
  output logic [DATA_W-1:0]   b_rdata_o
);

  localparam int unsigned NumBytes = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Single process keeps both write ports on one driver; the owner arbitrates same-word access.
  always_ff @(negedge clk_i) begin
    if (b_en_i) begin
      if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
      b_rdata_o <= mem_q[b_addr_i];
    end
    if (a_en_i) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (a_we_i[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
      a_rdata_o <= mem_q[a_addr_i];
    end
  end

endmodule

// File: rtl/dual_port_ram.sv
// Dual-port RAM bank: CPU port A has priority, region-decoded debug port B, optional clear on reset.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_W         = DefaultDataW,
  parameter int unsigned DEPTH          = DefaultDepth,
  parameter int unsigned REGION_BIT     = 14,
  parameter bit          REGION_VAL     = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           CE,
  dual_port_ram_if.slave bus,
  output logic           init_done
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              init_q, init_d;
  logic              a_pend_q, b_pend_q;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic [DATA_W-1:0] a_ram_rdata, b_ram_rdata;

  logic              running, clearing, collide;
  logic              a_acc, b_acc, a_rd, b_rd;
  logic [ADDR_W-1:0] b_word;
  logic              unused_b_addr;

  assign unused_b_addr = ^bus.b_addr;

  assign clearing = (state_q == StClear);
  assign running  = (state_q == StRun) && init_q;
  assign b_word   = bus.b_addr[ADDR_W+1:2];
  assign bus.b_hit = (bus.b_addr[REGION_BIT] == REGION_VAL);

  // Port A wins any same-word access unless both sides only read.
  assign collide = bus.a_req && (bus.a_addr == b_word) && ((bus.a_we != '0) || bus.b_we);

  assign bus.a_ready = running;
  assign bus.b_ready = running && !collide;

  assign a_acc = CE && running && bus.a_req;
  assign b_acc = CE && running && bus.b_req && !collide;
  assign a_rd  = a_acc && (bus.a_we == '0);
  assign b_rd  = b_acc && bus.b_hit && !bus.b_we;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (clearing) begin
      clr_d = clr_q + ADDR_W'(1);
      if (clr_q == ADDR_W'(DEPTH - 1)) state_d = StRun;
    end
    init_d = (state_d == StRun);
  end

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= CLEAR_ON_RESET ? StClear : StRun;
      clr_q      <= '0;
      init_q     <= 1'b0;
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else if (CE) begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      init_q     <= init_d;
      a_pend_q   <= a_rd;
      b_pend_q   <= b_rd;
      a_rvalid_q <= a_pend_q;
      b_rvalid_q <= b_pend_q;
      if (a_pend_q) a_rdata_q <= a_ram_rdata;
      if (b_pend_q) b_rdata_q <= b_ram_rdata;
    end
  end

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign init_done    = init_q;

  ram_array_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (CLK),
    .a_en_i    (CE && (clearing || a_acc)),
    .a_we_i    (clearing ? '1 : bus.a_we),
    .a_addr_i  (clearing ? clr_q : bus.a_addr),
    .a_wdata_i (clearing ? '0 : bus.a_wdata),
    .a_rdata_o (a_ram_rdata),
    .b_en_i    (b_acc && bus.b_hit),
    .b_we_i    (bus.b_we),
    .b_addr_i  (b_word),
    .b_wdata_i (bus.b_wdata),
    .b_rdata_o (b_ram_rdata)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram with a behavioural memory model and read-data scoreboard.
module tb_dual_port_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic CLK = 1'b1;
  logic RST_N;
  logic CE;
  logic init_done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];
  logic          model_run;
  logic          a_pipe, b_pipe, a_vld, b_vld;
  logic [DW-1:0] a_last, b_last;

  dual_port_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dual_port_ram #(
    .DATA_W         (DW),
    .DEPTH          (DEPTH),
    .REGION_BIT     (14),
    .REGION_VAL     (1'b0),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CE        (CE),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.a_req = 1'b0; bus.a_we = '0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  task automatic model_reset();
    model_run = 1'b0;
    a_pipe = 1'b0; b_pipe = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    a_last = '0; b_last = '0;
    a_q.delete(); b_q.delete();
  endtask

  // Checks the current cycle's combinational outputs, predicts the edge, then checks registered ones.
  task automatic step();
    logic          hit, coll, a_acc, b_acc, a_rd, b_rd, ce_now;
    logic [AW-1:0] bw;
    #1;
    bw   = bus.b_addr[AW+1:2];
    hit  = (bus.b_addr[14] == 1'b0);
    coll = bus.a_req && (bus.a_addr == bw) && ((bus.a_we != '0) || bus.b_we);
    chkb("a_ready", bus.a_ready, model_run);
    chkb("b_ready", bus.b_ready, model_run && !coll);
    chkb("b_hit", bus.b_hit, hit);
    a_acc = CE && model_run && bus.a_req;
    b_acc = CE && model_run && bus.b_req && !coll;
    a_rd  = a_acc && (bus.a_we == '0);
    b_rd  = b_acc && hit && !bus.b_we;
    if (a_rd) a_q.push_back(mem_m[bus.a_addr]);
    if (b_rd) b_q.push_back(mem_m[bw]);
    if (b_acc && hit && bus.b_we) mem_m[bw] = bus.b_wdata;
    if (a_acc) begin
      for (int i = 0; i < DW / 8; i++) begin
        if (bus.a_we[i]) mem_m[bus.a_addr][8*i +: 8] = bus.a_wdata[8*i +: 8];
      end
    end
    ce_now = CE;
    @(negedge CLK);
    #1;
    if (ce_now) begin
      a_vld = a_pipe; b_vld = b_pipe;
      a_pipe = a_rd; b_pipe = b_rd;
      if (a_vld) a_last = a_q.pop_front();
      if (b_vld) b_last = b_q.pop_front();
    end
    chkb("a_rvalid", bus.a_rvalid, a_vld);
    chk("a_rdata", bus.a_rdata, a_last);
    chkb("b_rvalid", bus.b_rvalid, b_vld);
    chk("b_rdata", bus.b_rdata, b_last);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 40) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk(tag, DW'(n), DW'(DEPTH));
    chk("rdata_after_clear", bus.a_rdata, '0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    model_run = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); bus.a_req = 1'b1; bus.a_addr = AW'(i); step();
    end
    idle(); step(); step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;
    model_reset();
    idle();
    CE = 1'b1;
    RST_N = 1'b0;
    #2;
    chkb("rst_init_done", init_done, 1'b0);
    chkb("rst_a_rvalid", bus.a_rvalid, 1'b0);
    chk("rst_a_rdata", bus.a_rdata, '0);
    chk("rst_b_rdata", bus.b_rdata, '0);
    chkb("rst_a_ready", bus.a_ready, 1'b0);
    @(negedge CLK); #1;
    RST_N = 1'b1;
    wait_clear("clear_cycles");
    read_all();

    // Byte-masked write then read back
    idle(); bus.a_req = 1'b1; bus.a_we = 4'b0011; bus.a_addr = 4'd5; bus.a_wdata = 32'hDEADBEEF;
    step();
    idle(); bus.a_req = 1'b1; bus.a_addr = 4'd5; step();
    idle(); step(); step();

    // Collision: A writes word 3 while B reads byte address 0x0C
    idle(); bus.a_req = 1'b1; bus.a_we = 4'hF; bus.a_addr = 4'd3; bus.a_wdata = 32'h12345678;
    bus.b_req = 1'b1; bus.b_addr = 32'h0000_000C;
    step();
    bus.a_req = 1'b0; bus.a_we = '0; step();
    idle(); step(); step();

    // Simultaneous reads of one word
    idle(); bus.a_req = 1'b1; bus.a_addr = 4'd5; bus.b_req = 1'b1; bus.b_addr = 32'h14;
    step();
    idle(); step(); step();

    // Out-of-region B write is swallowed
    idle(); bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 32'h0000_4010;
    bus.b_wdata = 32'hCAFEF00D;
    step();
    idle(); bus.a_req = 1'b1; bus.a_addr = 4'd4; step();
    idle(); step(); step();

    // B full-word write, then both ports read it
    idle(); bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 32'h18; bus.b_wdata = 32'hA5A55A5A;
    step();
    idle(); bus.b_req = 1'b1; bus.b_addr = 32'h18; bus.a_req = 1'b1; bus.a_addr = 4'd6; step();
    idle(); step(); step();

    // A write followed immediately by B read of the same word
    idle(); bus.a_req = 1'b1; bus.a_we = 4'hF; bus.a_addr = 4'd7; bus.a_wdata = 32'h01020304;
    step();
    idle(); bus.b_req = 1'b1; bus.b_addr = 32'h1C; step();
    idle(); step(); step();

    // CE pattern 1,0,0,1 across a read
    idle(); bus.a_req = 1'b1; bus.a_addr = 4'd5; CE = 1'b1; step();
    idle(); CE = 1'b0; step(); step();
    CE = 1'b1; step(); step();

    // Asynchronous reset while read data is valid
    idle(); bus.a_req = 1'b1; bus.a_addr = 4'd5; step();
    idle(); step();
    RST_N = 1'b0;
    #1;
    chkb("async_rst_rvalid", bus.a_rvalid, 1'b0);
    chk("async_rst_rdata", bus.a_rdata, '0);
    chkb("async_rst_init_done", init_done, 1'b0);
    model_reset();
    @(negedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 7; i++) step();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    wait_clear("reclear_cycles");
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL provide parameter DEPTH, default 4096, number of words (power of 2); ADDR_W = log2(DEPTH), derived.
REQ-003 SHALL provide parameter REGION_BIT, default 14, byte-address bit that selects this bank on port B.
REQ-004 SHALL provide parameter REGION_VAL, default 0, value of REGION_BIT that maps to this bank.
REQ-005 SHALL provide parameter CLEAR_ON_RESET, default 1; 1 = zero the array after reset, 0 = skip the clear.
REQ-006 Clock and reset are fixed: one clock, and reset is asynchronous and active-low.
REQ-007 SHALL have these ports: CLK  in  1  sole clock; all state changes on the falling edge of CLK.
REQ-008 RST_N  in  1  asynchronous, active-low reset.
REQ-009 CE  in  1  cycle enable (CPU clock qualifier); state advances only on edges where CE=1 ("active cycle").
REQ-010 a_req  in  1  port A (CPU) request.
REQ-011 a_we  in  DATA_W/8  port A byte write enables; 0 = read.
REQ-012 a_addr  in  ADDR_W  port A word address.
REQ-013 a_wdata  in  DATA_W  port A write data.
REQ-014 a_ready  out  1  port A request accepted this active cycle.
REQ-015 a_rdata / a_rvalid  out  DATA_W / 1  port A read data / valid.
REQ-016 b_req, b_we  in  1, 1  port B (debug/UART) request and full-word write.
REQ-017 b_addr  in  32  port B byte address; the word index is b_addr[ADDR_W+1:2].
REQ-018 b_wdata  in  DATA_W  port B write data.
REQ-019 b_ready, b_rdata, b_rvalid, b_hit  out  1, DATA_W, 1, 1  port B accept, read data, valid, in-range flag.
REQ-020 init_done  out  1  high once the clear sequence has completed.

Function
REQ-021 SHALL implement FSM states CLEAR and RUN: reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
REQ-022 CLEAR SHALL write zero to one word per active cycle, counter 0..DEPTH-1, entering RUN after word DEPTH-1 (DEPTH active cycles).
REQ-023 While in CLEAR, a_ready=b_ready=0 and init_done=0; in RUN, init_done=1.
REQ-024 b_hit SHALL be combinational: (b_addr[REGION_BIT]==REGION_VAL).
REQ-025 Accept rule: a request is accepted when req=1, ready=1 and CE=1; a_ready=1 throughout RUN.
REQ-026 b_ready SHALL be 1 in RUN except on a collision cycle: a_req=1, same word address, and (a_we!=0 or b_we=1).
REQ-027 On a collision port A SHALL win; port B holds its request and is accepted on the first non-colliding active cycle.
REQ-028 Simultaneous reads of the same word SHALL both be accepted.
REQ-029 Port A write SHALL update only the bytes whose a_we bit is set; port B write SHALL update the full word.
REQ-030 Read latency SHALL be 1 active cycle: rdata is updated and rvalid=1 on the active edge after acceptance.
REQ-031 rvalid SHALL be high for exactly one active cycle per accepted read; CE=0 holds all outputs.
REQ-032 rdata SHALL hold its last value between reads.
REQ-033 Writes SHALL NOT assert rvalid; a read of a word written in the previous cycle SHALL return the new data.
REQ-034 Port B request with b_hit=0 SHALL be accepted (b_ready=1) and discarded: no write, no rvalid, b_rdata unchanged.

Reset
REQ-035 RST_N low SHALL immediately set a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, init_done=0 and clear counter=0.
REQ-036 Reset during CLEAR SHALL restart the clear at word 0.
REQ-037 Array contents SHALL NOT be reset except by the CLEAR sequence.

Structure
REQ-038 Package dual_port_ram_pkg SHALL hold the FSM state enum and default DATA_W/DEPTH constants.
REQ-039 Storage SHALL be a sub-module ram_array_2p: two synchronous ports, byte-write on A, no reset, inferable as block RAM.

Verification
REQ-040 Reset with DEPTH=16, CLEAR_ON_RESET=1, CE=1 -> init_done rises after 16 active cycles; every word then reads 0x0.
REQ-041 A writes 0xDEADBEEF to word 5 with a_we=4'b0011, then reads word 5 -> a_rdata=0x0000BEEF, a_rvalid one cycle after accept.
REQ-042 Same cycle: A writes word 3, B reads byte address 0x0C -> b_ready=0 that cycle; B accepted next cycle and returns A's data.
REQ-043 B write with b_addr bit 14 = 1 and REGION_VAL=0 -> b_hit=0, b_ready=1, memory unchanged, no b_rvalid.
REQ-044 CE toggled 1,0,0,1 during a read -> a_rvalid asserts only on the second active edge and lasts one active cycle.
REQ-045 RST_N pulsed low at clear counter=7 -> counter restarts at 0, init_done rises 16 active cycles after release.
